// File: rtl/axi_pcie_axi_enhanced_rx_realigner.sv
// TRN RX realigner: shifts TLPs that start on any 64-bit lane (including straddled TLPs) onto lane 0.
// Optional statistics counters are enabled with `define AXI_PCIE_RX_REALIGN_STATS_EN.
module axi_pcie_axi_enhanced_rx_realigner #(
    parameter int C_DATA_WIDTH = 128,
    parameter     C_FAMILY     = "X7",
    parameter int TCQ          = 1,
    localparam int QWS        = C_DATA_WIDTH / 64,
    localparam int OFS_WIDTH  = (QWS > 1) ? $clog2(QWS) : 1,
    localparam int REM_WIDTH  = $clog2(C_DATA_WIDTH / 32),
    localparam int RBAR_WIDTH = (C_FAMILY == "X7") ? 8 : 7
) (
    input  logic                    com_iclk,
    input  logic                    com_sysrst_n,
    input  logic [C_DATA_WIDTH-1:0] trn_rd,
    input  logic                    trn_rsof,
    input  logic [OFS_WIDTH-1:0]    trn_rsof_ofs,
    input  logic                    trn_reof,
    input  logic [REM_WIDTH-1:0]    trn_rrem,
    input  logic                    trn_rsrc_rdy,
    output logic                    trn_rdst_rdy_o,
    input  logic                    trn_rsrc_dsc,
    input  logic                    trn_rerrfwd,
    input  logic [RBAR_WIDTH-1:0]   trn_rbar_hit,
    input  logic                    trn_recrc_err,
    output logic [C_DATA_WIDTH-1:0] trn_rd_o,
    output logic                    trn_rsof_o,
    output logic                    trn_reof_o,
    output logic                    trn_rsrc_rdy_o,
    output logic                    trn_rsrc_dsc_o,
    input  logic                    trn_rdst_rdy,
    output logic [REM_WIDTH-1:0]    trn_rrem_o,
    output logic                    trn_rerrfwd_o,
    output logic                    trn_recrc_err_o,
    output logic [RBAR_WIDTH-1:0]   trn_rbar_hit_o
`ifdef AXI_PCIE_RX_REALIGN_STATS_EN
    ,
    output logic [31:0]             stat_tlp_cnt,
    output logic [31:0]             stat_straddle_cnt,
    output logic [31:0]             stat_flush_cnt
`endif
);

    if (!(C_DATA_WIDTH == 64 || C_DATA_WIDTH == 128 || C_DATA_WIDTH == 256) || TCQ < 0) begin : g_bad_param
        $error("axi_pcie_axi_enhanced_rx_realigner: C_DATA_WIDTH must be 64, 128 or 256");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_PASS, ST_SHIFT, ST_FLUSH} state_t;

    function automatic logic [63:0] lane_of(input logic [C_DATA_WIDTH-1:0] d, input int i);
        return d[C_DATA_WIDTH-1-64*i -: 64];
    endfunction

    // Output lane i takes hi lane i+s, spilling into lo lanes; lanes past 'last' are zeroed.
    function automatic logic [C_DATA_WIDTH-1:0] realign(input logic [C_DATA_WIDTH-1:0] hi,
                                                        input logic [C_DATA_WIDTH-1:0] lo,
                                                        input int s, input int last);
        logic [C_DATA_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < QWS; i++) begin
            if (i <= last) begin
                if (i + s < QWS) r[C_DATA_WIDTH-1-64*i -: 64] = lane_of(hi, i + s);
                else             r[C_DATA_WIDTH-1-64*i -: 64] = lane_of(lo, i + s - QWS);
            end
        end
        return r;
    endfunction

    function automatic logic [REM_WIDTH-1:0] rem_adj(input logic [REM_WIDTH-1:0] rem, input int s);
        return REM_WIDTH'(int'(rem) - 2 * s);
    endfunction

    state_t                  state_q, state_d;
    logic [C_DATA_WIDTH-1:0] hold_p0, hold_d;
    logic [OFS_WIDTH-1:0]    shift_p0, shift_d, shift_nxt_p0, shift_nxt_d;
    logic                    strad_p0, strad_d, sof_pend_p0, sof_pend_d;
    logic [REM_WIDTH-1:0]    rrem_p0, rrem_hold_d;
    logic                    ecrc_p0, ecrc_hold_d;
    logic [RBAR_WIDTH-1:0]   bar_cur_p0, bar_cur_d, bar_nxt_p0, bar_nxt_d;
    logic                    errfwd_cur_p0, errfwd_cur_d, errfwd_nxt_p0, errfwd_nxt_d;

    logic [C_DATA_WIDTH-1:0] rd_d;
    logic                    sof_d, eof_d, rdy_d, dsc_d, ecrc_d, errfwd_d;
    logic [REM_WIDTH-1:0]    rrem_d;
    logic [RBAR_WIDTH-1:0]   bar_d;

    logic                    acc, dsc_acc, flush_enter;
    logic [OFS_WIDTH-1:0]    s_in;
    int                      s_in_i, s_cur_i, last_in_i, last_hold_i;

    assign trn_rdst_rdy_o = com_sysrst_n && trn_rdst_rdy && (state_q != ST_FLUSH);
    assign acc            = trn_rsrc_rdy && trn_rdst_rdy_o;
    assign dsc_acc        = trn_rsrc_dsc && trn_rdst_rdy_o;

    // A 64-bit datapath has a single lane, so the start offset is always zero.
    assign s_in        = (QWS > 1) ? trn_rsof_ofs : '0;
    assign s_in_i      = int'(s_in);
    assign s_cur_i     = int'(shift_p0);
    assign last_in_i   = int'(trn_rrem) >> 1;
    assign last_hold_i = int'(rrem_p0) >> 1;

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_p0;
        shift_d      = shift_p0;
        shift_nxt_d  = shift_nxt_p0;
        strad_d      = strad_p0;
        sof_pend_d   = sof_pend_p0;
        rrem_hold_d  = rrem_p0;
        ecrc_hold_d  = ecrc_p0;
        bar_cur_d    = bar_cur_p0;
        errfwd_cur_d = errfwd_cur_p0;
        bar_nxt_d    = bar_nxt_p0;
        errfwd_nxt_d = errfwd_nxt_p0;
        rd_d         = '0;
        sof_d        = 1'b0;
        eof_d        = 1'b0;
        rdy_d        = 1'b0;
        dsc_d        = 1'b0;
        ecrc_d       = 1'b0;
        rrem_d       = '0;
        bar_d        = trn_rbar_hit_o;
        errfwd_d     = trn_rerrfwd_o;
        flush_enter  = 1'b0;

        if (dsc_acc) begin
            dsc_d      = 1'b1;
            state_d    = ST_IDLE;
            hold_d     = '0;
            sof_pend_d = 1'b0;
            strad_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (acc && trn_rsof) begin
                        bar_cur_d    = trn_rbar_hit;
                        errfwd_cur_d = trn_rerrfwd;
                        if (s_in_i == 0) begin
                            rdy_d    = 1'b1;
                            sof_d    = 1'b1;
                            rd_d     = trn_rd;
                            eof_d    = trn_reof;
                            rrem_d   = trn_reof ? trn_rrem : '1;
                            ecrc_d   = trn_reof && trn_recrc_err;
                            bar_d    = trn_rbar_hit;
                            errfwd_d = trn_rerrfwd;
                            state_d  = trn_reof ? ST_IDLE : ST_PASS;
                        end else begin
                            hold_d     = trn_rd;
                            shift_d    = s_in;
                            sof_pend_d = 1'b1;
                            if (trn_reof) begin
                                rrem_hold_d = trn_rrem;
                                ecrc_hold_d = trn_recrc_err;
                                state_d     = ST_FLUSH;
                                flush_enter = 1'b1;
                            end else begin
                                state_d = ST_SHIFT;
                            end
                        end
                    end
                end
                ST_PASS: begin
                    if (acc) begin
                        rdy_d    = 1'b1;
                        rd_d     = trn_rd;
                        eof_d    = trn_reof;
                        rrem_d   = trn_reof ? trn_rrem : '1;
                        ecrc_d   = trn_reof && trn_recrc_err;
                        bar_d    = bar_cur_p0;
                        errfwd_d = errfwd_cur_p0;
                        if (trn_reof) begin
                            state_d = ST_IDLE;
                            if (trn_rsof && s_in_i > last_in_i) begin
                                hold_d       = trn_rd;
                                shift_d      = s_in;
                                sof_pend_d   = 1'b1;
                                bar_cur_d    = trn_rbar_hit;
                                errfwd_cur_d = trn_rerrfwd;
                                state_d      = ST_SHIFT;
                            end
                        end
                    end
                end
                ST_SHIFT: begin
                    if (acc) begin
                        rdy_d      = 1'b1;
                        sof_d      = sof_pend_p0;
                        sof_pend_d = 1'b0;
                        bar_d      = bar_cur_p0;
                        errfwd_d   = errfwd_cur_p0;
                        rd_d       = realign(hold_p0, trn_rd, s_cur_i, QWS - 1);
                        rrem_d     = '1;
                        hold_d     = trn_rd;
                        if (trn_reof) begin
                            if (last_in_i < s_cur_i) begin
                                eof_d   = 1'b1;
                                rrem_d  = rem_adj(trn_rrem, s_cur_i);
                                ecrc_d  = trn_recrc_err;
                                state_d = ST_IDLE;
                                if (trn_rsof && s_in_i > last_in_i) begin
                                    shift_d      = s_in;
                                    sof_pend_d   = 1'b1;
                                    bar_cur_d    = trn_rbar_hit;
                                    errfwd_cur_d = trn_rerrfwd;
                                    state_d      = ST_SHIFT;
                                end
                            end else begin
                                // Tail spills past this beat; the next TLP (if any) waits behind the flush.
                                rrem_hold_d = trn_rrem;
                                ecrc_hold_d = trn_recrc_err;
                                state_d     = ST_FLUSH;
                                flush_enter = 1'b1;
                                if (trn_rsof && s_in_i > last_in_i) begin
                                    strad_d      = 1'b1;
                                    shift_nxt_d  = s_in;
                                    bar_nxt_d    = trn_rbar_hit;
                                    errfwd_nxt_d = trn_rerrfwd;
                                end
                            end
                        end
                    end
                end
                ST_FLUSH: begin
                    if (trn_rdst_rdy) begin
                        rdy_d      = 1'b1;
                        eof_d      = 1'b1;
                        sof_d      = sof_pend_p0;
                        sof_pend_d = 1'b0;
                        rd_d       = realign(hold_p0, hold_p0, s_cur_i, last_hold_i - s_cur_i);
                        rrem_d     = rem_adj(rrem_p0, s_cur_i);
                        ecrc_d     = ecrc_p0;
                        bar_d      = bar_cur_p0;
                        errfwd_d   = errfwd_cur_p0;
                        strad_d    = 1'b0;
                        state_d    = ST_IDLE;
                        if (strad_p0) begin
                            shift_d      = shift_nxt_p0;
                            bar_cur_d    = bar_nxt_p0;
                            errfwd_cur_d = errfwd_nxt_p0;
                            sof_pend_d   = 1'b1;
                            state_d      = (shift_nxt_p0 == '0) ? ST_PASS : ST_SHIFT;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Stage p0 -> output register boundary
    always_ff @(posedge com_iclk) begin
        if (!com_sysrst_n) begin
            state_q         <= ST_IDLE;
            hold_p0         <= '0;
            shift_p0        <= '0;
            shift_nxt_p0    <= '0;
            strad_p0        <= 1'b0;
            sof_pend_p0     <= 1'b0;
            rrem_p0         <= '0;
            ecrc_p0         <= 1'b0;
            bar_cur_p0      <= '0;
            errfwd_cur_p0   <= 1'b0;
            bar_nxt_p0      <= '0;
            errfwd_nxt_p0   <= 1'b0;
            trn_rd_o        <= '0;
            trn_rsof_o      <= 1'b0;
            trn_reof_o      <= 1'b0;
            trn_rsrc_rdy_o  <= 1'b0;
            trn_rsrc_dsc_o  <= 1'b0;
            trn_rrem_o      <= '0;
            trn_rerrfwd_o   <= 1'b0;
            trn_recrc_err_o <= 1'b0;
            trn_rbar_hit_o  <= '0;
        end else begin
            state_q       <= state_d;
            hold_p0       <= hold_d;
            shift_p0      <= shift_d;
            shift_nxt_p0  <= shift_nxt_d;
            strad_p0      <= strad_d;
            sof_pend_p0   <= sof_pend_d;
            rrem_p0       <= rrem_hold_d;
            ecrc_p0       <= ecrc_hold_d;
            bar_cur_p0    <= bar_cur_d;
            errfwd_cur_p0 <= errfwd_cur_d;
            bar_nxt_p0    <= bar_nxt_d;
            errfwd_nxt_p0 <= errfwd_nxt_d;
            if (trn_rdst_rdy) begin
                trn_rd_o        <= rd_d;
                trn_rsof_o      <= sof_d;
                trn_reof_o      <= eof_d;
                trn_rsrc_rdy_o  <= rdy_d;
                trn_rsrc_dsc_o  <= dsc_d;
                trn_rrem_o      <= rrem_d;
                trn_rerrfwd_o   <= errfwd_d;
                trn_recrc_err_o <= ecrc_d;
                trn_rbar_hit_o  <= bar_d;
            end
        end
    end

`ifdef AXI_PCIE_RX_REALIGN_STATS_EN
    always_ff @(posedge com_iclk) begin
        if (!com_sysrst_n) begin
            stat_tlp_cnt      <= '0;
            stat_straddle_cnt <= '0;
            stat_flush_cnt    <= '0;
        end else begin
            if (trn_rdst_rdy && rdy_d && eof_d) stat_tlp_cnt <= stat_tlp_cnt + 32'd1;
            if (acc && trn_rsof && trn_reof)    stat_straddle_cnt <= stat_straddle_cnt + 32'd1;
            if (flush_enter)                    stat_flush_cnt <= stat_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axi_pcie_axi_enhanced_rx_realigner.sv
// Directed bench for the RX realigner: 128-bit instance for most scenarios, 256-bit instance for wide shifts.
module tb_axi_pcie_axi_enhanced_rx_realigner;

    logic com_iclk = 1'b0;
    always #5 com_iclk = ~com_iclk;
    logic com_sysrst_n;

    logic [127:0] rd, rd_o;
    logic         rsof, reof, rsrc_rdy, rsrc_dsc, rerrfwd, recrc_err, rdst_rdy;
    logic [0:0]   rsof_ofs;
    logic [1:0]   rrem, rrem_o;
    logic [7:0]   rbar, rbar_o;
    logic         rdst_rdy_o, rsof_o, reof_o, rsrc_rdy_o, rsrc_dsc_o, rerrfwd_o, recrc_err_o;

    logic [255:0] w_rd, w_rd_o;
    logic         w_rsof, w_reof, w_rsrc_rdy, w_rsrc_dsc, w_rerrfwd, w_recrc_err, w_rdst_rdy;
    logic [1:0]   w_rsof_ofs;
    logic [2:0]   w_rrem, w_rrem_o;
    logic [7:0]   w_rbar, w_rbar_o;
    logic         w_rdst_rdy_o, w_rsof_o, w_reof_o, w_rsrc_rdy_o, w_rsrc_dsc_o, w_rerrfwd_o, w_recrc_err_o;

`ifdef AXI_PCIE_RX_REALIGN_STATS_EN
    logic [31:0] s_tlp, s_strad, s_flush, ws_tlp, ws_strad, ws_flush;
`endif

    axi_pcie_axi_enhanced_rx_realigner #(.C_DATA_WIDTH(128)) dut (
        .com_iclk(com_iclk), .com_sysrst_n(com_sysrst_n),
        .trn_rd(rd), .trn_rsof(rsof), .trn_rsof_ofs(rsof_ofs), .trn_reof(reof), .trn_rrem(rrem),
        .trn_rsrc_rdy(rsrc_rdy), .trn_rdst_rdy_o(rdst_rdy_o), .trn_rsrc_dsc(rsrc_dsc),
        .trn_rerrfwd(rerrfwd), .trn_rbar_hit(rbar), .trn_recrc_err(recrc_err),
        .trn_rd_o(rd_o), .trn_rsof_o(rsof_o), .trn_reof_o(reof_o), .trn_rsrc_rdy_o(rsrc_rdy_o),
        .trn_rsrc_dsc_o(rsrc_dsc_o), .trn_rdst_rdy(rdst_rdy), .trn_rrem_o(rrem_o),
        .trn_rerrfwd_o(rerrfwd_o), .trn_recrc_err_o(recrc_err_o), .trn_rbar_hit_o(rbar_o)
`ifdef AXI_PCIE_RX_REALIGN_STATS_EN
        , .stat_tlp_cnt(s_tlp), .stat_straddle_cnt(s_strad), .stat_flush_cnt(s_flush)
`endif
    );

    axi_pcie_axi_enhanced_rx_realigner #(.C_DATA_WIDTH(256)) dut256 (
        .com_iclk(com_iclk), .com_sysrst_n(com_sysrst_n),
        .trn_rd(w_rd), .trn_rsof(w_rsof), .trn_rsof_ofs(w_rsof_ofs), .trn_reof(w_reof), .trn_rrem(w_rrem),
        .trn_rsrc_rdy(w_rsrc_rdy), .trn_rdst_rdy_o(w_rdst_rdy_o), .trn_rsrc_dsc(w_rsrc_dsc),
        .trn_rerrfwd(w_rerrfwd), .trn_rbar_hit(w_rbar), .trn_recrc_err(w_recrc_err),
        .trn_rd_o(w_rd_o), .trn_rsof_o(w_rsof_o), .trn_reof_o(w_reof_o), .trn_rsrc_rdy_o(w_rsrc_rdy_o),
        .trn_rsrc_dsc_o(w_rsrc_dsc_o), .trn_rdst_rdy(w_rdst_rdy), .trn_rrem_o(w_rrem_o),
        .trn_rerrfwd_o(w_rerrfwd_o), .trn_recrc_err_o(w_recrc_err_o), .trn_rbar_hit_o(w_rbar_o)
`ifdef AXI_PCIE_RX_REALIGN_STATS_EN
        , .stat_tlp_cnt(ws_tlp), .stat_straddle_cnt(ws_strad), .stat_flush_cnt(ws_flush)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge com_iclk);
        #1;
    endtask

    // Control tuple {dsc, rdy, sof, eof, rrem, ecrc}; data only compared on emitted beats.
    task automatic beat128(input string tag, input logic rdy, input logic sof, input logic eof,
                           input logic [1:0] rem, input logic ecrc, input logic [127:0] data);
        chk({tag, ".ctl"}, 256'({rsrc_dsc_o, rsrc_rdy_o, rsof_o, reof_o, rrem_o, recrc_err_o}),
            256'({1'b0, rdy, sof, eof, rem, ecrc}));
        if (rdy) chk({tag, ".data"}, 256'(rd_o), 256'(data));
    endtask

    task automatic beat256(input string tag, input logic rdy, input logic sof, input logic eof,
                           input logic [2:0] rem, input logic [255:0] data);
        chk({tag, ".ctl"}, 256'({w_rsrc_dsc_o, w_rsrc_rdy_o, w_rsof_o, w_reof_o, w_rrem_o, w_recrc_err_o}),
            256'({1'b0, rdy, sof, eof, rem, 1'b0}));
        if (rdy) chk({tag, ".data"}, w_rd_o, data);
    endtask

    task automatic in128(input logic vld, input logic sof, input logic ofs, input logic eof,
                         input logic [1:0] rem, input logic [127:0] data, input logic [7:0] bar);
        rsrc_rdy = vld; rsof = sof; rsof_ofs = ofs; reof = eof; rrem = rem; rd = data; rbar = bar;
    endtask

    task automatic in256(input logic vld, input logic sof, input logic [1:0] ofs, input logic eof,
                         input logic [2:0] rem, input logic [255:0] data, input logic [7:0] bar);
        w_rsrc_rdy = vld; w_rsof = sof; w_rsof_ofs = ofs; w_reof = eof; w_rrem = rem; w_rd = data; w_rbar = bar;
    endtask

    initial begin
        com_sysrst_n = 1'b0;
        rsrc_dsc = 0; rerrfwd = 0; recrc_err = 0; rdst_rdy = 1;
        w_rsrc_dsc = 0; w_rerrfwd = 0; w_recrc_err = 0; w_rdst_rdy = 1;
        in128(0, 0, 0, 0, 0, '0, 8'h00);
        in256(0, 0, 0, 0, 0, '0, 8'h00);
        tick(); tick();
        chk("rst.rdst_rdy_o", 256'(rdst_rdy_o), 256'(0));
        chk("rst.outs", 256'({rsrc_rdy_o, rsof_o, reof_o, rsrc_dsc_o, rrem_o, rbar_o, rerrfwd_o, recrc_err_o, rd_o}), 256'(0));
        com_sysrst_n = 1'b1;
        #1;
        chk("rel.rdst_rdy_o", 256'(rdst_rdy_o), 256'(1));

        // 3DW TLP on lane 0 passes through untouched
        rerrfwd = 1;
        in128(1, 1, 0, 1, 2'd2, {64'hA0, 64'hA1}, 8'h01);
        tick();
        rerrfwd = 0;
        beat128("t1", 1, 1, 1, 2'd2, 0, {64'hA0, 64'hA1});
        chk("t1.side", 256'({rbar_o, rerrfwd_o}), 256'({8'h01, 1'b1}));
        in128(0, 0, 0, 0, 0, '0, 8'h00);
        tick();
        beat128("t1.idle", 0, 0, 0, 0, 0, '0);

        // Aligned multi-beat TLP with a downstream stall on its last beat
        in128(1, 1, 0, 0, 2'd0, {64'hB0, 64'hB1}, 8'h07);
        tick();
        beat128("bp.b1", 1, 1, 0, 2'd3, 0, {64'hB0, 64'hB1});
        rdst_rdy = 0;
        in128(1, 0, 0, 1, 2'd1, {64'hB2, 64'hB3}, 8'h00);
        #1;
        chk("bp.rdst_rdy_o", 256'(rdst_rdy_o), 256'(0));
        tick();
        beat128("bp.hold", 1, 1, 0, 2'd3, 0, {64'hB0, 64'hB1});
        rdst_rdy = 1;
        tick();
        beat128("bp.b2", 1, 0, 1, 2'd1, 0, {64'hB2, 64'hB3});
        chk("bp.bar", 256'(rbar_o), 256'(8'h07));
        in128(0, 0, 0, 0, 0, '0, 8'h00);
        tick();

        // 4DW TLP starting on lane 1, eof on lane 0 of the next beat
        in128(1, 1, 1, 0, 2'd0, {64'hFF00, 64'hC0}, 8'h02);
        tick();
        beat128("t2.b1", 0, 0, 0, 2'd0, 0, '0);
        recrc_err = 1;
        in128(1, 0, 0, 1, 2'd1, {64'hC1, 64'hEE}, 8'h00);
        tick();
        recrc_err = 0;
        beat128("t2.b2", 1, 1, 1, 2'd3, 1, {64'hC0, 64'hC1});
        chk("t2.bar", 256'(rbar_o), 256'(8'h02));
        in128(0, 0, 0, 0, 0, '0, 8'h00);
        tick();

        // Shifted TLP whose tail spills into a flush beat
        in128(1, 1, 1, 0, 2'd0, {64'h11, 64'hD0}, 8'h03);
        tick();
        in128(1, 0, 0, 1, 2'd3, {64'hD1, 64'hD2}, 8'h00);
        tick();
        beat128("t3.full", 1, 1, 0, 2'd3, 0, {64'hD0, 64'hD1});
        chk("t3.rdst_rdy_o_flush", 256'(rdst_rdy_o), 256'(0));
        in128(0, 0, 0, 0, 0, '0, 8'h00);
        tick();
        beat128("t3.flush", 1, 0, 1, 2'd1, 0, {64'hD2, 64'h0});
        chk("t3.rdst_rdy_o_after", 256'(rdst_rdy_o), 256'(1));
        tick();

        // Single-beat TLP on lane 1 goes straight to flush
        in128(1, 1, 1, 1, 2'd3, {64'h22, 64'hE0}, 8'h04);
        tick();
        beat128("sb.none", 0, 0, 0, 2'd0, 0, '0);
        chk("sb.rdst_rdy_o", 256'(rdst_rdy_o), 256'(0));
        in128(0, 0, 0, 0, 0, '0, 8'h00);
        tick();
        beat128("sb.flush", 1, 1, 1, 2'd1, 0, {64'hE0, 64'h0});
        tick();

        // Straddle: old TLP ends on lane 0 while the next starts on lane 1
        in128(1, 1, 1, 0, 2'd0, {64'h33, 64'hF0}, 8'h03);
        tick();
        in128(1, 1, 1, 1, 2'd1, {64'hF1, 64'h90}, 8'h04);
        tick();
        beat128("t4.old", 1, 1, 1, 2'd3, 0, {64'hF0, 64'hF1});
        chk("t4.old_bar", 256'(rbar_o), 256'(8'h03));
        in128(1, 0, 0, 1, 2'd1, {64'h91, 64'h44}, 8'h00);
        tick();
        beat128("t4.new", 1, 1, 1, 2'd3, 0, {64'h90, 64'h91});
        chk("t4.new_bar", 256'(rbar_o), 256'(8'h04));
        in128(0, 0, 0, 0, 0, '0, 8'h00);
        tick();

        // Discontinue mid shifted TLP, then a clean aligned TLP
        in128(1, 1, 1, 0, 2'd0, {64'h0, 64'h50}, 8'h05);
        tick();
        rsrc_dsc = 1;
        in128(1, 0, 0, 0, 2'd0, {64'h51, 64'h52}, 8'h00);
        tick();
        rsrc_dsc = 0;
        chk("t6.dsc", 256'({rsrc_dsc_o, rsrc_rdy_o, reof_o}), 256'({1'b1, 1'b0, 1'b0}));
        in128(1, 1, 0, 1, 2'd3, {64'h60, 64'h61}, 8'h06);
        tick();
        beat128("t6.clean", 1, 1, 1, 2'd3, 0, {64'h60, 64'h61});
        in128(0, 0, 0, 0, 0, '0, 8'h00);
        tick();

        // Reset in the middle of a shifted TLP drops it
        in128(1, 1, 1, 0, 2'd0, {64'h0, 64'h70}, 8'h08);
        tick();
        com_sysrst_n = 0;
        in128(1, 0, 0, 1, 2'd1, {64'h71, 64'h0}, 8'h00);
        tick();
        chk("mr.outs", 256'({rsrc_rdy_o, rsof_o, reof_o, rd_o}), 256'(0));
        com_sysrst_n = 1;
        in128(1, 1, 0, 1, 2'd1, {64'h80, 64'h81}, 8'h09);
        tick();
        beat128("mr.after", 1, 1, 1, 2'd1, 0, {64'h80, 64'h81});
        in128(0, 0, 0, 0, 0, '0, 8'h00);

        // 256-bit: 8DW TLP starting on lane 3
        in256(1, 1, 2'd3, 0, 3'd0, {64'hE1, 64'hE2, 64'hE3, 64'hA0}, 8'h5A);
        tick();
        beat256("w8.b1", 0, 0, 0, 3'd0, '0);
        in256(1, 0, 2'd0, 1, 3'd5, {64'hA1, 64'hA2, 64'hA3, 64'hE4}, 8'h00);
        tick();
        beat256("w8.b2", 1, 1, 1, 3'd7, {64'hA0, 64'hA1, 64'hA2, 64'hA3});
        chk("w8.bar", 256'(w_rbar_o), 256'(8'h5A));
        in256(0, 0, 2'd0, 0, 3'd0, '0, 8'h00);
        tick();

        // 256-bit: 12DW TLP on lane 3, BAR input changes mid-TLP
        in256(1, 1, 2'd3, 0, 3'd0, {64'hE1, 64'hE2, 64'hE3, 64'hB0}, 8'h3C);
        tick();
        in256(1, 0, 2'd0, 0, 3'd0, {64'hB1, 64'hB2, 64'hB3, 64'hB4}, 8'hC3);
        tick();
        beat256("w12.b1", 1, 1, 0, 3'd7, {64'hB0, 64'hB1, 64'hB2, 64'hB3});
        chk("w12.bar1", 256'(w_rbar_o), 256'(8'h3C));
        in256(1, 0, 2'd0, 1, 3'd1, {64'hB5, 64'hD1, 64'hD2, 64'hD3}, 8'hFF);
        tick();
        beat256("w12.b2", 1, 0, 1, 3'd3, {64'hB4, 64'hB5, 64'hD1, 64'hD2});
        chk("w12.bar2", 256'({w_rbar_o, w_rerrfwd_o, w_rdst_rdy_o}), 256'({8'h3C, 1'b0, 1'b1}));
        in256(0, 0, 2'd0, 0, 3'd0, '0, 8'h00);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
